// File: rtl/conv_maxpool2x2.sv
// 2x2 stride-2 signed max pooling over a row-major conv result stream.
// Pairs from even rows are folded into a half-width line buffer and merged with the odd row.
module conv_maxpool2x2 #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 98,
    parameter int IMG_H      = 98
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    input  logic                  running_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  running_o,
    output logic                  frame_done_o
);

    localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB_DEPTH = (IMG_W / 2 > 0) ? IMG_W / 2 : 1;
    localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE, WAIT_LOW} state_t;

    state_t                        state, state_nxt;
    logic [CW-1:0]                 col, col_cur;
    logic [RW-1:0]                 row, row_cur;
    logic signed [DATA_WIDTH-1:0]  hold, din_s, lb_rd, pair_max, win_max;
    logic signed [DATA_WIDTH-1:0]  linebuf [LB_DEPTH];
    logic [LBW-1:0]                lb_idx;
    logic                          start, accept, last_col, last_row, frame_end;

    function automatic logic signed [DATA_WIDTH-1:0] smax(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // A sample may be accepted in the same cycle IDLE hands over to RUN,
    // so the position counters read as zero while still in IDLE.
    assign start     = (state == IDLE) && running_i;
    assign accept    = (start || (state == RUN)) && running_i && valid_i;
    assign col_cur   = (state == IDLE) ? '0 : col;
    assign row_cur   = (state == IDLE) ? '0 : row;
    assign last_col  = (col_cur == CW'(IMG_W - 1));
    assign last_row  = (row_cur == RW'(IMG_H - 1));
    assign frame_end = accept && last_col && last_row;

    assign din_s    = $signed(data_i);
    assign lb_idx   = LBW'(col_cur >> 1);
    assign lb_rd    = linebuf[lb_idx];
    assign pair_max = smax(hold, din_s);
    assign win_max  = smax(lb_rd, pair_max);

    always_comb begin
        state_nxt    = state;
        running_o    = 1'b0;
        frame_done_o = 1'b0;
        case (state)
            IDLE: begin
                if (running_i) state_nxt = frame_end ? DONE : RUN;
            end
            RUN: begin
                running_o = 1'b1;
                if (!running_i)     state_nxt = IDLE;
                else if (frame_end) state_nxt = DONE;
            end
            DONE: begin
                running_o    = 1'b1;
                frame_done_o = 1'b1;
                state_nxt    = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!running_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            col     <= '0;
            row     <= '0;
            hold    <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            valid_o <= 1'b0;
            if (state == IDLE) begin
                col  <= '0;
                row  <= '0;
                hold <= '0;
            end
            if (accept) begin
                col <= last_col ? '0 : col_cur + CW'(1);
                if (last_col) row <= last_row ? '0 : row_cur + RW'(1);
                if (!col_cur[0]) hold <= din_s;
                if (row_cur[0] && col_cur[0]) begin
                    data_o  <= win_max;
                    valid_o <= 1'b1;
                end
            end
        end
    end

    // Line buffer contents are don't-care after reset; no reset needed.
    always_ff @(posedge clk) begin
        if (accept && !row_cur[0] && col_cur[0]) linebuf[lb_idx] <= pair_max;
    end

endmodule

// File: tb/tb_conv_maxpool2x2.sv
// Directed bench for conv_maxpool2x2: three sized instances, scoreboard of pooled samples
// with expected arrival cycle, checked by a negedge monitor.
module tb_conv_maxpool2x2;

    typedef struct {
        int          id;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] din  [3];
    logic        vin  [3];
    logic        rin  [3];
    logic [15:0] dout [3];
    logic        vout [3];
    logic        rout [3];
    logic        fd   [3];

    exp_t sb[$];
    int   checks;
    int   errors;
    int   cyc;
    int   fd_cnt [3];
    int   exp_fd [3];

    conv_maxpool2x2 #(.DATA_WIDTH(16), .IMG_W(4), .IMG_H(4)) u_p44 (
        .clk(clk), .rst(rst), .data_i(din[0]), .valid_i(vin[0]), .running_i(rin[0]),
        .data_o(dout[0]), .valid_o(vout[0]), .running_o(rout[0]), .frame_done_o(fd[0]));
    conv_maxpool2x2 #(.DATA_WIDTH(16), .IMG_W(5), .IMG_H(5)) u_p55 (
        .clk(clk), .rst(rst), .data_i(din[1]), .valid_i(vin[1]), .running_i(rin[1]),
        .data_o(dout[1]), .valid_o(vout[1]), .running_o(rout[1]), .frame_done_o(fd[1]));
    conv_maxpool2x2 #(.DATA_WIDTH(16), .IMG_W(4), .IMG_H(2)) u_p42 (
        .clk(clk), .rst(rst), .data_i(din[2]), .valid_i(vin[2]), .running_i(rin[2]),
        .data_o(dout[2]), .valid_o(vout[2]), .running_o(rout[2]), .frame_done_o(fd[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pix(input int mode, input int w, input int r, input int c);
        case (mode)
            0:       return 16'(r * w + c);
            1:       return (r == 0 && c == 0) ? 16'hFFC0 : 16'hFFE0;
            default: return 16'(((r * 7919 + c * 4099) * 40503) >>> 3);
        endcase
    endfunction

    // Reference window max, computed straight from the pixel generator.
    function automatic logic [15:0] pool(input int mode, input int w, input int r, input int c);
        logic signed [15:0] m, v;
        m = $signed(pix(mode, w, r, c));
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
                v = $signed(pix(mode, w, r - dr, c - dc));
                if (v > m) m = v;
            end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_frame(input int id, input int w, input int h, input int mode,
                             input bit gaps, input int stop_after);
        int n;
        bit aborted;
        n       = 0;
        aborted = 0;
        rin[id] = 1'b1;
        for (int r = 0; r < h && !aborted; r++)
            for (int c = 0; c < w && !aborted; c++) begin
                if (gaps) begin
                    vin[id] = 1'b0;
                    @(posedge clk); #1;
                end
                din[id] = pix(mode, w, r, c);
                vin[id] = 1'b1;
                if (r[0] && c[0] && r < 2 * (h / 2) && c < 2 * (w / 2))
                    sb.push_back('{id, pool(mode, w, r, c), cyc + 1});
                @(posedge clk); #1;
                if (stop_after >= 0 && n == stop_after) aborted = 1;
                n++;
            end
        vin[id] = 1'b0;
        if (aborted) begin
            rin[id] = 1'b0;
            @(posedge clk); #1;
            check($sformatf("abort_running_d%0d", id), rout[id], 0);
            check($sformatf("abort_no_done_d%0d", id), fd[id], 0);
        end else begin
            check($sformatf("done_pulse_d%0d", id), fd[id], 1);
            check($sformatf("done_running_d%0d", id), rout[id], 1);
            check($sformatf("done_last_valid_d%0d", id), vout[id], (w % 2 == 0 && h % 2 == 0));
            exp_fd[id]++;
            // Stray sample while running_i is still high must be ignored.
            din[id] = 16'h7FFF;
            vin[id] = 1'b1;
            @(posedge clk); #1;
            check($sformatf("wait_low_running_d%0d", id), rout[id], 0);
            check($sformatf("wait_low_done_d%0d", id), fd[id], 0);
            @(posedge clk); #1;
            vin[id] = 1'b0;
            rin[id] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("sb_drained_d%0d", id), sb.size(), 0);
        check($sformatf("done_count_d%0d", id), fd_cnt[id], exp_fd[id]);
    endtask

    initial begin
        exp_t e;
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din[i] = '0; vin[i] = 1'b0; rin[i] = 1'b0;
            fd_cnt[i] = 0; exp_fd[i] = 0;
        end

        fork
            forever begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    if (fd[i] === 1'b1) fd_cnt[i]++;
                    if (vout[i] === 1'b1) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $error("FAIL unexpected_valid_d%0d: observed data %0h expected no output", i, dout[i]);
                        end else begin
                            e = sb.pop_front();
                            check("out_dut", i, e.id);
                            check($sformatf("out_data_d%0d", i), dout[i], e.data);
                            check($sformatf("out_cycle_d%0d", i), cyc, e.cyc);
                            check($sformatf("out_running_d%0d", i), rout[i], 1);
                        end
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_data_d%0d", i), dout[i], 0);
            check($sformatf("rst_valid_d%0d", i), vout[i], 0);
            check($sformatf("rst_running_d%0d", i), rout[i], 0);
            check($sformatf("rst_done_d%0d", i), fd[i], 0);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        run_frame(0, 4, 4, 0, 0, -1);   // 5 7 13 15
        run_frame(1, 5, 5, 0, 0, -1);   // 6 8 16 18
        run_frame(2, 4, 2, 1, 0, -1);   // signed: FFE0 FFE0
        run_frame(0, 4, 4, 0, 1, -1);   // valid gaps
        run_frame(0, 4, 4, 0, 0, 5);    // abort with output 5 in flight
        run_frame(0, 4, 4, 0, 0, -1);

        // Asynchronous reset in the middle of a frame.
        rin[0] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            din[0] = 16'(k);
            vin[0] = 1'b1;
            if (k == 5) sb.push_back('{0, 16'd5, cyc + 1});
            @(posedge clk); #1;
        end
        vin[0] = 1'b0;
        check("pre_rst_data", dout[0], 5);
        check("pre_rst_running", rout[0], 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_data", dout[0], 0);
        check("mid_rst_valid", vout[0], 0);
        check("mid_rst_running", rout[0], 0);
        check("mid_rst_done", fd[0], 0);
        rin[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 4, 4, 0, 0, -1);
        run_frame(1, 5, 5, 2, 1, -1);   // mixed-sign pattern with gaps

        check("sb_final", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
